// File: rtl/abs_tile_scheduler.sv
// Round-robin scheduler sharing one absolute-difference engine among NUM_CH tile sources.
// Buffers the granted tile, holds eng_valid for the fixed scan window and tags the result with its channel.
module abs_tile_scheduler #(
  parameter int TILE_SIZE = 8,
  parameter int NUM_CH    = 3,
  parameter int RUN_CYC   = 9,
  parameter int TIMEOUT   = 15
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CH-1:0]                     req_valid,
  input  logic [NUM_CH*8*TILE_SIZE*TILE_SIZE-1:0] req_data,
  output logic [NUM_CH-1:0]                     req_ready,
  input  logic                                  sink_ready,
  output logic                                  eng_valid,
  output logic [8*TILE_SIZE*TILE_SIZE-1:0]      eng_data,
  input  logic                                  eng_done,
  output logic                                  res_valid,
  output logic [1:0]                            res_ch,
  output logic                                  busy,
  output logic                                  err_timeout,
  output logic [15:0]                           tiles_done
);

  localparam int TILE_W = 8 * TILE_SIZE * TILE_SIZE;
  localparam int RUN_W  = $clog2(RUN_CYC + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t              state, state_n;
  logic [1:0]          rr_ptr, rr_nxt, gnt_idx;
  logic [RUN_W-1:0]    run_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot, gnt_oh;
  logic                gnt_found, grant, timeout_hit;
  logic [TILE_W-1:0]   gnt_tile;
  int                  gnt_off, gnt_sum;

  // Round-robin arbiter: rotate requests so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl   = {req_valid, req_valid};
    req_rot   = NUM_CH'(req_dbl >> rr_ptr);
    gnt_found = 1'b0;
    gnt_off   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_found && req_rot[i]) begin
        gnt_found = 1'b1;
        gnt_off   = i;
      end
    end
    gnt_sum = int'(rr_ptr) + gnt_off;
    if (gnt_sum >= NUM_CH) gnt_sum = gnt_sum - NUM_CH;
    gnt_idx = 2'(gnt_sum);
    rr_nxt  = (gnt_sum + 1 >= NUM_CH) ? 2'd0 : 2'(gnt_sum + 1);
    gnt_oh  = NUM_CH'(1) << gnt_idx;
    gnt_tile = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_idx == 2'(c)) gnt_tile = req_data[c*TILE_W +: TILE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    req_ready   = '0;
    grant       = 1'b0;
    res_valid   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && sink_ready && gnt_found) begin
          grant     = 1'b1;
          req_ready = gnt_oh;
          state_n   = RUN;
        end
      end
      RUN: begin
        if (run_cnt == RUN_LAST) state_n = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          res_valid = 1'b1;
          state_n   = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Job datapath: tile buffer, scan-window counter, wait watchdog and result bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_valid   <= 1'b0;
      eng_data    <= '0;
      res_ch      <= 2'd0;
      rr_ptr      <= 2'd0;
      run_cnt     <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      tiles_done  <= 16'd0;
    end else begin
      if (grant) begin
        eng_data  <= gnt_tile;
        res_ch    <= gnt_idx;
        rr_ptr    <= rr_nxt;
        eng_valid <= 1'b1;
        run_cnt   <= '0;
      end
      if (state == RUN) begin
        run_cnt <= run_cnt + RUN_W'(1);
        if (run_cnt == RUN_LAST) begin
          eng_valid <= 1'b0;
          wait_cnt  <= '0;
        end
      end
      if (state == WAIT && !eng_done) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (timeout_hit) err_timeout <= 1'b1;
      if (res_valid)   tiles_done  <= tiles_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_abs_tile_scheduler.sv
// Directed bench for abs_tile_scheduler: grant order, scan window, backpressure, timeout, spurious done, reset mid-job.
module tb_abs_tile_scheduler;
  localparam int T  = 8;
  localparam int NC = 3;
  localparam int TW = 8 * T * T;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req_valid;
  logic [NC*TW-1:0]  req_data;
  logic [NC-1:0]     req_ready;
  logic              sink_ready;
  logic              eng_valid;
  logic [TW-1:0]     eng_data;
  logic              eng_done;
  logic              res_valid;
  logic [1:0]        res_ch;
  logic              busy;
  logic              err_timeout;
  logic [15:0]       tiles_done;

  logic [TW-1:0]     tile [NC];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  abs_tile_scheduler #(.TILE_SIZE(T), .NUM_CH(NC), .RUN_CYC(9), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .sink_ready(sink_ready), .eng_valid(eng_valid), .eng_data(eng_data), .eng_done(eng_done),
    .res_valid(res_valid), .res_ch(res_ch), .busy(busy), .err_timeout(err_timeout),
    .tiles_done(tiles_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; sink_ready = 1'b0; eng_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  // Counts negedges with eng_valid high starting from now; returns at first low sample.
  task automatic wait_eng_low(output int hi);
    hi = 0;
    while (eng_valid === 1'b1 && hi <= 40) begin
      hi++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; sink_ready = 1'b0; eng_done = 1'b0;
    repeat (2) @(negedge clk); #1;
    n_cmp++;
    if ({eng_valid, res_valid, busy, err_timeout, res_ch, tiles_done, req_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ev=%b rv=%b busy=%b err=%b ch=%0d done=%0d rdy=%b want all 0",
               eng_valid, res_valid, busy, err_timeout, res_ch, tiles_done, req_ready);
    end
    n_cmp++;
    if (eng_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", eng_data); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if ({busy, eng_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_release: got busy=%b ev=%b want 0 0", busy, eng_valid);
    end
  endtask

  task automatic test_single();
    int hi;
    req_valid = 3'b001; sink_ready = 1'b1; #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin n_err++; $display("FAIL t1_grant: got %b want 001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_cmp++;
    if (req_ready !== 3'b000) begin n_err++; $display("FAIL t1_grant_once: got %b want 000", req_ready); end
    n_cmp++;
    if (eng_data !== tile[0]) begin n_err++; $display("FAIL t1_data: got %h want %h", eng_data, tile[0]); end
    wait_eng_low(hi);
    n_cmp++;
    if (hi !== 9) begin n_err++; $display("FAIL t1_run_len: got %0d want 9", hi); end
    eng_done = 1'b1; #1;
    n_cmp++;
    if ({res_valid, res_ch} !== 3'b100) begin
      n_err++; $display("FAIL t1_result: got rv=%b ch=%0d want rv=1 ch=0", res_valid, res_ch);
    end
    @(negedge clk); eng_done = 1'b0; #1;
    n_cmp++;
    if ({res_valid, busy, tiles_done} !== {1'b0, 1'b0, 16'd1}) begin
      n_err++; $display("FAIL t1_after: got rv=%b busy=%b done=%0d want 0 0 1", res_valid, busy, tiles_done);
    end
  endtask

  task automatic test_round_robin();
    int hi, k, last;
    logic [1:0] exp_ch [4];
    exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2; exp_ch[3] = 2'd0;
    last = 0;
    do_reset();
    req_valid = 3'b111; sink_ready = 1'b1; #1;
    for (int j = 0; j < 4; j++) begin
      k = 0;
      while (req_ready === 3'b000 && k < 30) begin @(negedge clk); #1; k++; end
      n_cmp++;
      if (req_ready !== (3'b001 << exp_ch[j])) begin
        n_err++; $display("FAIL t2_grant%0d: got %b want %b", j, req_ready, 3'b001 << exp_ch[j]);
      end
      n_cmp++;
      if (eng_valid !== 1'b0) begin n_err++; $display("FAIL t2_gap%0d: got ev=%b want 0", j, eng_valid); end
      if (j > 0) begin
        n_cmp++;
        if (cyc - last !== 11) begin n_err++; $display("FAIL t2_spacing%0d: got %0d want 11", j, cyc - last); end
      end
      last = cyc;
      @(negedge clk); #1;
      if (j == 3) req_valid = '0;
      n_cmp++;
      if (res_ch !== exp_ch[j] || eng_data !== tile[exp_ch[j]]) begin
        n_err++; $display("FAIL t2_job%0d: got ch=%0d want ch=%0d (data match=%b)",
                          j, res_ch, exp_ch[j], eng_data === tile[exp_ch[j]]);
      end
      wait_eng_low(hi);
      n_cmp++;
      if (hi !== 9) begin n_err++; $display("FAIL t2_run_len%0d: got %0d want 9", j, hi); end
      eng_done = 1'b1; #1;
      n_cmp++;
      if (res_valid !== 1'b1) begin n_err++; $display("FAIL t2_res%0d: got %b want 1", j, res_valid); end
      @(negedge clk); eng_done = 1'b0; #1;
    end
    n_cmp++;
    if (tiles_done !== 16'd4) begin n_err++; $display("FAIL t2_count: got %0d want 4", tiles_done); end
  endtask

  task automatic test_backpressure();
    int hi;
    do_reset();
    sink_ready = 1'b0; req_valid = 3'b010; #1;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if ({req_ready, busy} !== 4'b0000) begin
        n_err++; $display("FAIL t3_hold%0d: got rdy=%b busy=%b want 000 0", i, req_ready, busy);
      end
      @(negedge clk); #1;
    end
    sink_ready = 1'b1; #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin n_err++; $display("FAIL t3_grant: got %b want 010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_cmp++;
    if (res_ch !== 2'd1) begin n_err++; $display("FAIL t3_ch: got %0d want 1", res_ch); end
    wait_eng_low(hi);
    eng_done = 1'b1; @(negedge clk); eng_done = 1'b0; #1;
    n_cmp++;
    if (tiles_done !== 16'd1) begin n_err++; $display("FAIL t3_count: got %0d want 1", tiles_done); end
  endtask

  task automatic test_timeout();
    int hi, w;
    bit saw;
    req_valid = 3'b001; #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin n_err++; $display("FAIL t4_grant: got %b want 001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    wait_eng_low(hi);
    n_cmp++;
    if (hi !== 9) begin n_err++; $display("FAIL t4_run_len: got %0d want 9", hi); end
    w = 0; saw = 1'b0;
    while (busy === 1'b1 && w < 40) begin
      w++;
      if (res_valid !== 1'b0) saw = 1'b1;
      @(negedge clk); #1;
    end
    n_cmp++;
    if (w !== 15) begin n_err++; $display("FAIL t4_wait_len: got %0d want 15", w); end
    n_cmp++;
    if ({err_timeout, saw, tiles_done} !== {1'b1, 1'b0, 16'd1}) begin
      n_err++; $display("FAIL t4_abort: got err=%b res_seen=%b done=%0d want 1 0 1", err_timeout, saw, tiles_done);
    end
    req_valid = 3'b100; #1;
    n_cmp++;
    if (req_ready !== 3'b100) begin n_err++; $display("FAIL t4_next_grant: got %b want 100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    wait_eng_low(hi);
    eng_done = 1'b1; @(negedge clk); eng_done = 1'b0; #1;
    n_cmp++;
    if ({err_timeout, tiles_done} !== {1'b1, 16'd2}) begin
      n_err++; $display("FAIL t4_sticky: got err=%b done=%0d want 1 2", err_timeout, tiles_done);
    end
  endtask

  task automatic test_spurious_done();
    int hi;
    eng_done = 1'b1; #1;
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL t5_idle_done: got rv=%b busy=%b want 0 0", res_valid, busy);
    end
    @(negedge clk); eng_done = 1'b0; #1;
    n_cmp++;
    if ({busy, tiles_done} !== {1'b0, 16'd2}) begin
      n_err++; $display("FAIL t5_idle_state: got busy=%b done=%0d want 0 2", busy, tiles_done);
    end
    req_valid = 3'b010; #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin n_err++; $display("FAIL t5_grant: got %b want 010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    repeat (3) begin @(negedge clk); #1; end
    eng_done = 1'b1; #1;
    n_cmp++;
    if ({res_valid, eng_valid} !== 2'b01) begin
      n_err++; $display("FAIL t5_run_done: got rv=%b ev=%b want 0 1", res_valid, eng_valid);
    end
    @(negedge clk); eng_done = 1'b0; #1;
    wait_eng_low(hi);
    n_cmp++;
    if (hi !== 5) begin n_err++; $display("FAIL t5_run_rest: got %0d want 5", hi); end
    eng_done = 1'b1; #1;
    n_cmp++;
    if ({res_valid, res_ch} !== 3'b101) begin
      n_err++; $display("FAIL t5_result: got rv=%b ch=%0d want 1 1", res_valid, res_ch);
    end
    @(negedge clk); eng_done = 1'b0; #1;
    n_cmp++;
    if (tiles_done !== 16'd3) begin n_err++; $display("FAIL t5_count: got %0d want 3", tiles_done); end
  endtask

  task automatic test_reset_mid_run();
    int hi;
    req_valid = 3'b001; #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin n_err++; $display("FAIL t6_grant: got %b want 001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    repeat (4) begin @(negedge clk); #1; end
    n_cmp++;
    if (eng_valid !== 1'b1) begin n_err++; $display("FAIL t6_running: got %b want 1", eng_valid); end
    rst_n = 1'b0; req_valid = 3'b100; #1;
    n_cmp++;
    if ({eng_valid, busy, err_timeout, res_valid, tiles_done, req_ready} !== '0) begin
      n_err++; $display("FAIL t6_async: got ev=%b busy=%b err=%b rv=%b done=%0d rdy=%b want all 0",
                        eng_valid, busy, err_timeout, res_valid, tiles_done, req_ready);
    end
    n_cmp++;
    if (eng_data !== '0) begin n_err++; $display("FAIL t6_data_clr: got %h want 0", eng_data); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (req_ready !== 3'b100) begin n_err++; $display("FAIL t6_regrant: got %b want 100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_cmp++;
    if (res_ch !== 2'd2 || eng_data !== tile[2]) begin
      n_err++; $display("FAIL t6_job: got ch=%0d want 2 (data match=%b)", res_ch, eng_data === tile[2]);
    end
    wait_eng_low(hi);
    n_cmp++;
    if (hi !== 9) begin n_err++; $display("FAIL t6_run_len: got %0d want 9", hi); end
    eng_done = 1'b1; @(negedge clk); eng_done = 1'b0; #1;
    n_cmp++;
    if ({tiles_done, err_timeout} !== {16'd1, 1'b0}) begin
      n_err++; $display("FAIL t6_count: got done=%0d err=%b want 1 0", tiles_done, err_timeout);
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < T * T; i++)
        tile[c][i*8 +: 8] = 8'(c * 64 + i);
    req_data = {tile[2], tile[1], tile[0]};
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_spurious_done();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
